// File: rtl/fifo_rr_scheduler.sv
// fifo_rr_scheduler: drains four source FIFOs into four destination FIFOs.
// Build option FIFO_SCHED_PRIO_EN makes source 0 strict priority.
module fifo_rr_scheduler #(
  parameter int DATA_WIDTH = 6,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    reset_L,
  input  logic [3:0]              src_empty,
  input  logic [4*DATA_WIDTH-1:0] src_data,
  output logic [3:0]              src_pop,
  input  logic [3:0]              dst_pausa,
  output logic [3:0]              dst_push,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    idle,
  output logic [CNT_WIDTH-1:0]    word_cnt
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    CAPT = 3'd2,
    HOLD = 3'd3,
    PUSH = 3'd4
  } state_t;

  state_t state_q;
  state_t state_n;

  logic [1:0] grant_q;
  logic [1:0] grant_n;
  logic [1:0] rr_q;
  logic [1:0] rr_n;
  logic [1:0] dest_q;
  logic [1:0] dest_n;
  logic [1:0] pick;
  logic       pick_ok;
  logic       start_ok;

  logic [DATA_WIDTH-1:0] cap_word;
  logic [1:0]            cap_dest;

  function automatic logic [3:0] oh4(input logic [1:0] i);
    return 4'b0001 << i;
  endfunction

`ifdef FIFO_SCHED_PRIO_EN
  // Step k places after b within the 1..3 ring.
  function automatic logic [1:0] rr3(
    input logic [1:0] b,
    input int         k
  );
    int v;
    v = ((int'(b) - 1 + k) % 3) + 1;
    return 2'(v);
  endfunction
`endif

  // Mux the granted source's read data.
  always_comb begin
    cap_word = '0;
    for (int i = 0; i < 4; i++) begin
      if (grant_q == 2'(i)) begin
        cap_word = src_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign cap_dest = cap_word[DATA_WIDTH-1:DATA_WIDTH-2];

  // Pointer as seen by this cycle's search (PUSH retires grant).
  always_comb begin
    rr_n = rr_q;
    if (state_q == PUSH) begin
`ifdef FIFO_SCHED_PRIO_EN
      if (grant_q != 2'd0) begin
        rr_n = grant_q;
      end
`else
      rr_n = grant_q;
`endif
    end
  end

  // Choose the next non-empty source after the pointer.
  always_comb begin
    pick    = 2'd0;
    pick_ok = 1'b0;
`ifdef FIFO_SCHED_PRIO_EN
    if (!src_empty[0]) begin
      pick_ok = 1'b1;
    end else begin
      for (int k = 1; k <= 3; k++) begin
        if (!pick_ok && !src_empty[rr3(rr_n, k)]) begin
          pick    = rr3(rr_n, k);
          pick_ok = 1'b1;
        end
      end
    end
`else
    for (int k = 1; k <= 4; k++) begin
      if (!pick_ok && !src_empty[rr_n + 2'(k)]) begin
        pick    = rr_n + 2'(k);
        pick_ok = 1'b1;
      end
    end
`endif
  end

  // A new read only starts with no destination asking to pause.
  assign start_ok = pick_ok & ~(|dst_pausa);

  // Next-state, grant and destination selection.
  always_comb begin
    state_n = state_q;
    grant_n = grant_q;
    dest_n  = dest_q;
    unique case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_n = READ;
          grant_n = pick;
        end
      end
      READ: begin
        state_n = CAPT;
      end
      CAPT: begin
        dest_n  = cap_dest;
        state_n = dst_pausa[cap_dest] ? HOLD : PUSH;
      end
      HOLD: begin
        if (!dst_pausa[dest_q]) begin
          state_n = PUSH;
        end
      end
      PUSH: begin
        if (start_ok) begin
          state_n = READ;
          grant_n = pick;
        end else begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and arbitration registers.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= IDLE;
      grant_q <= 2'd0;
      rr_q    <= 2'd3;
      dest_q  <= 2'd0;
    end else begin
      state_q <= state_n;
      grant_q <= grant_n;
      rr_q    <= rr_n;
      dest_q  <= dest_n;
    end
  end

  // Strobes and idle come straight from flops.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      src_pop  <= 4'b0000;
      dst_push <= 4'b0000;
      idle     <= 1'b1;
    end else begin
      src_pop  <= (state_n == READ) ? oh4(grant_n) : 4'b0000;
      dst_push <= (state_n == PUSH) ? oh4(dest_n) : 4'b0000;
      idle     <= (state_n == IDLE) & (&src_empty);
    end
  end

  // Captured word and transfer counter.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      data_out <= '0;
      word_cnt <= '0;
    end else begin
      if (state_q == CAPT) begin
        data_out <= cap_word;
      end
      if (state_n == PUSH) begin
        word_cnt <= word_cnt + 1'b1;
      end
    end
  end

`ifndef SYNTHESIS
  // Strobe sanity.
  always_ff @(posedge clk) begin
    if (reset_L) begin
      assert ($onehot0(src_pop));
      assert ($onehot0(dst_push));
      assert (!(|src_pop && |dst_push));
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// tb_fifo_rr_scheduler: directed + random checks against a queue model.
// Source FIFOs are modelled with one-cycle read latency.
module tb_fifo_rr_scheduler;

  logic        clk = 1'b0;
  logic        reset_L = 1'b0;
  logic [3:0]  src_empty = 4'hF;
  logic [23:0] src_data = '0;
  logic [3:0]  src_pop;
  logic [3:0]  dst_pausa = 4'h0;
  logic [3:0]  dst_push;
  logic [5:0]  data_out;
  logic        idle;
  logic [7:0]  word_cnt;

  fifo_rr_scheduler #(.DATA_WIDTH(6), .CNT_WIDTH(8)) dut (
    .clk       (clk),
    .reset_L   (reset_L),
    .src_empty (src_empty),
    .src_data  (src_data),
    .src_pop   (src_pop),
    .dst_pausa (dst_pausa),
    .dst_push  (dst_push),
    .data_out  (data_out),
    .idle      (idle),
    .word_cnt  (word_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cycno = 0;
  int last_rr = 3;
  int m_cnt = 0;
  int n_push = 0;

  logic [5:0] q0[$];
  logic [5:0] q1[$];
  logic [5:0] q2[$];
  logic [5:0] q3[$];
  logic [5:0] exp_q[$];
  int pop_log[$];
  int pop_cyc[$];

  logic [3:0] o_pop = '0;
  logic [3:0] o_push = '0;
  logic [5:0] o_data = '0;
  logic [7:0] o_cnt = '0;
  logic       o_idle = 1'b0;
  logic [3:0] prev_empty = 4'hF;
  logic [3:0] prev_pausa = 4'h0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int qsize(input int s);
    case (s)
      0: return q0.size();
      1: return q1.size();
      2: return q2.size();
      3: return q3.size();
      default: return 0;
    endcase
  endfunction

  function automatic logic [5:0] qpop(input int s);
    case (s)
      0: return q0.pop_front();
      1: return q1.pop_front();
      2: return q2.pop_front();
      3: return q3.pop_front();
      default: return 6'h00;
    endcase
  endfunction

  task automatic load(input int s, input logic [5:0] w);
    case (s)
      0: q0.push_back(w);
      1: q1.push_back(w);
      2: q2.push_back(w);
      default: q3.push_back(w);
    endcase
    src_empty[s] = 1'b0;
  endtask

  // Expected grant given the empty flags seen at decision time.
  function automatic int predict(input logic [3:0] emp);
`ifdef FIFO_SCHED_PRIO_EN
    if (!emp[0]) return 0;
    for (int k = 1; k <= 3; k++) begin
      int i;
      i = ((last_rr - 1 + k) % 3) + 1;
      if (!emp[i]) return i;
    end
`else
    for (int k = 1; k <= 4; k++) begin
      int i;
      i = (last_rr + k) % 4;
      if (!emp[i]) return i;
    end
`endif
    return -1;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    last_rr = 3;
    m_cnt = 0;
    prev_empty = src_empty;
    prev_pausa = dst_pausa;
  endtask

  // One clock: observe at negedge, then update source model after edge.
  task automatic cyc();
    int s;
    int p;
    logic [5:0] w;
    @(negedge clk);
    cycno++;
    o_pop = src_pop;
    o_push = dst_push;
    o_data = data_out;
    o_cnt = word_cnt;
    o_idle = idle;
    chk("pop_on_empty", o_pop & src_empty, 0);
    chk("strobe_excl",
        {$onehot0(o_pop), $onehot0(o_push), !(|o_pop && |o_push)},
        3'b111);
    s = -1;
    for (int i = 0; i < 4; i++) if (o_pop[i] && s < 0) s = i;
    if (s >= 0) begin
      p = predict(prev_empty);
      chk("grant", s, p);
      chk("throttle", prev_pausa, 0);
`ifdef FIFO_SCHED_PRIO_EN
      if (s != 0) last_rr = s;
`else
      last_rr = s;
`endif
      pop_log.push_back(s);
      pop_cyc.push_back(cycno);
    end
    if (|o_push) begin
      if (exp_q.size() == 0) begin
        chk("push_unexpected", o_push, 0);
      end else begin
        w = exp_q.pop_front();
        chk("push_dest", o_push, 4'b0001 << w[5:4]);
        chk("push_data", o_data, w);
        m_cnt = (m_cnt + 1) % 256;
        n_push++;
        chk("push_cnt", o_cnt, m_cnt);
      end
    end
    prev_empty = src_empty;
    prev_pausa = dst_pausa;
    @(posedge clk);
    #1;
    if (s >= 0 && qsize(s) > 0) begin
      w = qpop(s);
      src_data[s*6 +: 6] = w;
      exp_q.push_back(w);
      src_empty[s] = (qsize(s) == 0);
    end
  endtask

  task automatic do_reset();
    reset_L = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_L = 1'b1;
    model_reset();
    cyc();
  endtask

  task automatic drain(input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      cyc();
      if (qsize(0) + qsize(1) + qsize(2) + qsize(3) == 0 &&
          exp_q.size() == 0 && o_idle) done = 1'b1;
    end
    chk(tag, done, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_seq[5];
    int base;
    bit got;

    // Reset values and quiet idle.
    repeat (2) @(negedge clk);
    chk("rst_pop", src_pop, 0);
    chk("rst_push", dst_push, 0);
    chk("rst_data", data_out, 0);
    chk("rst_cnt", word_cnt, 0);
    chk("rst_idle", idle, 1);
    reset_L = 1'b1;
    model_reset();
    cyc();
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk("empty_idle", o_idle, 1);
      chk("empty_pop", o_pop, 0);
      chk("empty_push", o_push, 0);
    end
    chk("empty_cnt", o_cnt, 0);

    // Single word from source 2 to destination 1.
    load(2, 6'h1A);
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (|o_pop) break;
    end
    chk("s2_pop", o_pop, 4'b0100);
    cyc();
    cyc();
    chk("s2_push", o_push, 4'b0010);
    chk("s2_data", o_data, 6'h1A);
    chk("s2_cnt", o_cnt, 1);
    drain("s2_drain");
    chk("s2_keep", o_data, 6'h1A);

    // All sources busy: grant order and back-to-back spacing.
    do_reset();
    pop_log.delete();
    pop_cyc.delete();
`ifdef FIFO_SCHED_PRIO_EN
    for (int i = 0; i < 3; i++) load(0, 6'($urandom_range(0, 15)));
    for (int s = 1; s < 4; s++) load(s, 6'($urandom_range(0, 15)));
    exp_seq = '{0, 0, 0, 1, 2};
`else
    for (int s = 0; s < 4; s++) begin
      load(s, 6'($urandom_range(0, 15)));
      load(s, 6'($urandom_range(0, 15)));
    end
    exp_seq = '{0, 1, 2, 3, 0};
`endif
    for (int i = 0; i < 40 && pop_log.size() < 5; i++) cyc();
    chk("rr_count", pop_log.size() >= 5, 1);
    for (int i = 0; i < 5 && i < pop_log.size(); i++)
      chk("rr_order", pop_log[i], exp_seq[i]);
    for (int i = 1; i < 5 && i < pop_cyc.size(); i++)
      chk("rr_spacing", pop_cyc[i] - pop_cyc[i-1], 3);
    drain("rr_drain");

    // Throttle while a destination pauses, then hold on dest 3.
    dst_pausa = 4'b0100;
    load(1, 6'h3F);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("throttle_pop", o_pop, 0);
    end
    dst_pausa = 4'b0000;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (|o_pop) break;
    end
    chk("hold_pop", o_pop, 4'b0010);
    dst_pausa = 4'b1000;
    load(0, 6'($urandom_range(0, 63)));
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("hold_nopush", o_push, 0);
      chk("hold_nopop", o_pop, 0);
    end
    dst_pausa = 4'b0000;
    cyc();
    chk("hold_last", o_push, 0);
    cyc();
    chk("hold_push", o_push, 4'b1000);
    chk("hold_data", o_data, 6'h3F);
    drain("hold_drain");

    // Asynchronous reset while a word is being captured.
    load(0, 6'h2B);
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (|o_pop) break;
    end
    chk("ar_pop", o_pop, 4'b0001);
    #2;
    reset_L = 1'b0;
    #1;
    chk("ar_pop0", src_pop, 0);
    chk("ar_push0", dst_push, 0);
    chk("ar_data0", data_out, 0);
    chk("ar_cnt0", word_cnt, 0);
    chk("ar_idle", idle, 1);
    @(negedge clk);
    reset_L = 1'b1;
    model_reset();
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("ar_nopush", o_push, 0);
    end
    chk("ar_cnt", o_cnt, 0);

    // 256 random transfers with random pauses: counter wraps.
    do_reset();
    base = n_push;
    for (int i = 0; i < 256; i++)
      load($urandom_range(0, 3), 6'($urandom_range(0, 63)));
    got = 1'b0;
    for (int i = 0; i < 6000 && !got; i++) begin
      dst_pausa = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      cyc();
      if (n_push - base >= 256 && exp_q.size() == 0) got = 1'b1;
    end
    dst_pausa = 4'b0000;
    chk("wrap_total", n_push - base, 256);
    chk("wrap_cnt", o_cnt, 0);
    drain("wrap_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_rr_scheduler.md
Name: fifo_rr_scheduler

Overview:
- Arbiter and sequencer that drains four source threshold FIFOs into four destination FIFOs over one shared 6-bit path.
- Each cycle of work grants one non-empty source, pops one word and routes it by its two MSBs to a destination FIFO.
- Honours each destination's Pausa (almost-full) flag.
- Sits between the input FIFO bank and the output FIFO bank; owns every pop/push strobe of both banks.

Parameters:
DATA_WIDTH, 6, word width; destination selected by bits [DATA_WIDTH-1:DATA_WIDTH-2]
CNT_WIDTH, 8, width of transferred-word counter

Ports:
clk  in  1  clock
reset_L  in  1  asynchronous active-low reset
src_empty  in  4  Fifo_Empty of source FIFOs 0..3
src_data  in  4*DATA_WIDTH  Fifo_Data_out of source i at [i*DATA_WIDTH +: DATA_WIDTH]
src_pop  out  4  one-hot pop to source FIFOs
dst_pausa  in  4  Pausa of destination FIFOs 0..3
dst_push  out  4  one-hot push to destination FIFOs
data_out  out  DATA_WIDTH  word driven to all destination Fifo_Data_in
idle  out  1  1 when in IDLE and all src_empty=1
word_cnt  out  CNT_WIDTH  words pushed since reset, wraps to 0

Behaviour:
- Reset (async, reset_L=0): state=IDLE, rr_ptr=3 (so source 0 wins first), src_pop=0, dst_push=0, data_out=0, word_cnt=0, idle=1. Reset mid-transfer drops the in-flight word; no strobe may glitch on reset release.
- All outputs decode from registered state/grant/data only; no combinational input-to-output path.
- States: IDLE, READ, CAPT, HOLD, PUSH.
- IDLE: if any src_empty=0 and no dst_pausa bit set, grant = first non-empty source searching rr_ptr+1, rr_ptr+2, ... mod 4 -> READ; else stay.
- READ (1 cycle): src_pop[grant]=1. A granted source is never popped while empty.
- CAPT (1 cycle): src_data slice [grant] is valid (source memory read latency 1). Word registered at end of cycle into data_out; dest=word[5:4]. If dst_pausa[dest]=1 sampled this cycle -> HOLD, else -> PUSH.
- HOLD: data_out held, dst_push=0; -> PUSH in the cycle after dst_pausa[dest] samples 0.
- PUSH (1 cycle): dst_push[dest]=1, data_out stable; word_cnt+1 (mod 2^CNT_WIDTH); rr_ptr=grant. Then either:
  - -> READ directly with the next grant if the IDLE condition holds this cycle (back-to-back; throughput 1 word / 3 cycles), or
  - -> IDLE.
- Throttle: a new READ is never started while any dst_pausa bit is 1; this bounds in-flight data to one word.
- src_pop and dst_push are each at most one-hot; both are never 1 in the same cycle.
- Fairness: each continuously non-empty source is served at least once every 4 grants.
- data_out keeps the last pushed word while IDLE.

Optional Feature:
FIFO_SCHED_PRIO_EN
- Defined: source 0 is strict priority. Whenever src_empty[0]=0 at grant time, source 0 is granted. Sources 1..3 round-robin among themselves, with rr_ptr covering only 1..3. Source 0 grants do not update rr_ptr.
- Undefined: pure 4-way round-robin as above.

Test Plan:
- Reset then all sources empty, dst_pausa=0 -> idle=1, no pop/push for 20 cycles, word_cnt=0.
- Source 2 holds 6'h1A (dest 1), others empty -> src_pop=4'b0100 at cycle t, dst_push=4'b0010 with data_out=6'h1A at t+2, word_cnt=1.
- All four sources non-empty, words route to dest 0 -> grants 0,1,2,3,0 in order, back-to-back spacing of 3 cycles; with FIFO_SCHED_PRIO_EN and source 0 holding 3 words -> grants 0,0,0,1,2.
- Word 6'h3F (dest 3) captured while dst_pausa[3]=1 for 5 cycles -> HOLD for 5 cycles, dst_push=4'b1000 one cycle after release, no further src_pop meanwhile.
- reset_L pulsed low during CAPT -> outputs clear immediately (async); after release, the popped word is not pushed and word_cnt=0.
- 256 transfers -> word_cnt wraps to 0; no pop ever seen on a source whose src_empty=1 (assertion across whole run).
